axis_stream_fifo: RTL and testbench
===================================

// Module: axis_stream_fifo
// PURPOSE
//  Parametrised AXI-Stream buffer: successor to the single-word stream register.
//  Stores up to DEPTH beats of tdata/tlast with full valid/ready backpressure on both sides.
//  Optional store-and-forward (PACKET_MODE) presents a packet only once its tlast beat is stored.
//  Sits between fixed-point datapath stages (Q int_width.frac_width samples) to decouple stalls.
// PARAMETERS
//  data_width   8  beat width in bits
//  frac_width   6  fixed-point fraction bits; informational only, data is passed unmodified
//  int_width    2  fixed-point integer bits; data_width must equal int_width+frac_width
//  DEPTH        4  storage entries; power of two, >= 2
//  PACKET_MODE  0  0 = cut-through, 1 = store-and-forward on tlast
// PORTS
//  clk         in   1                    rising-edge clock
//  reset       in   1                    asynchronous, active-high reset
//  data_in     in   data_width           upstream beat data
//  tvalid_in   in   1                    upstream beat valid
//  tlast_in    in   1                    upstream end-of-packet marker
//  tready_out  out  1                    ready to upstream
//  data_out    out  data_width           downstream beat data
//  tvalid_out  out  1                    downstream beat valid
//  tlast_out   out  1                    downstream end-of-packet marker
//  tready_in   in   1                    ready from downstream
//  level       out  $clog2(DEPTH+1)      beats currently stored
//  pkt_count   out  $clog2(DEPTH+1)      complete packets (stored tlast beats) held
// BEHAVIOUR
//  - Reset (async, active-high): wr_ptr=rd_ptr=0, level=0, pkt_count=0; tready_out=1, tvalid_out=0,
//    data_out=0, tlast_out=0. Storage is not cleared. Inputs are ignored while reset is high.
//  - Push = tvalid_in & tready_out; pop = tvalid_out & tready_in. Both are evaluated at the same edge.
//  - tready_out = (level < DEPTH). It is decoded from registered state only, with no combinational path from tready_in.
//  - Storage is show-ahead: data_out/tlast_out = mem[rd_ptr]. Drive data_out=0 and tlast_out=0 whenever tvalid_out=0.
//  - Latency: a beat pushed at edge k is offered (tvalid_out=1) in the cycle after edge k if the FIFO was empty.
//  - tvalid_out:
//    - PACKET_MODE=0: level>0.
//    - PACKET_MODE=1: level>0 & (pkt_count>0 | level==DEPTH).
//  - Forced release: in PACKET_MODE, a FIFO that is full with no tlast stored forwards beats
//    cut-through. This prevents deadlock on packets longer than DEPTH. Forwarding stalls again
//    once level<DEPTH and pkt_count==0.
//  - Once asserted, tvalid_out and data_out are held stable until pop, except in the forced-release
//    case above, where tvalid_out may drop only after a pop.
//  - level: push-only +1; pop-only -1; push & pop together leaves level unchanged.
//  - pkt_count: +1 on a push with tlast_in=1; -1 on a pop with tlast_out=1; both together leaves it unchanged.
//  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH without a bubble.
//  - Full: push is impossible (tready_out=0). A pop in the full cycle frees the slot at the next edge.
//  - Empty: pop is impossible (tvalid_out=0). A push into an empty FIFO never bypasses the same cycle.
//  - Reset mid-packet: all stored beats and partial packets are discarded; the first beat after reset starts a new packet.
//  - level and pkt_count never exceed DEPTH; pkt_count <= level always holds.
// TESTING
//  1. Reset, then push 0x11,0x22,0x33 (tlast on 0x33) with tready_in=1, PACKET_MODE=0 ->
//     same order out, tvalid_out one cycle after each push, tlast_out only with 0x33, level returns to 0.
//  2. DEPTH=4, tready_in=0, push 5 beats ->
//     4 accepted, tready_out=0 with level=4; 5th beat held upstream; raising tready_in drains all 5 in order.
//  3. Continuous push and pop for 3*DEPTH beats (0x00..0x0B) ->
//     level constant, no dropped or duplicated beats across pointer wrap, throughput of 1 beat/cycle.
//  4. PACKET_MODE=1, push 0xA0,0xA1 (no tlast) ->
//     tvalid_out=0; push 0xA2 with tlast -> pkt_count=1, tvalid_out=1, 3 beats out, pkt_count returns to 0.
//  5. PACKET_MODE=1, DEPTH=4, 6-beat packet with tready_in=1 ->
//     forced release at level=4; all 6 beats delivered, tlast_out on beat 6, no deadlock.
//  6. Assert reset with level=3 and pkt_count=1 ->
//     all outputs reach their reset values asynchronously; the next push of 0x5A emerges first.

Source files
------------

// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO with show-ahead storage, full valid/ready backpressure and an
// optional store-and-forward mode that holds beats back until a tlast is stored.
module axis_stream_fifo #(
  parameter int data_width  = 8,
  parameter int frac_width  = 6,
  parameter int int_width   = 2,
  parameter int DEPTH       = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [data_width-1:0]        data_in,
  input  logic                         tvalid_in,
  input  logic                         tlast_in,
  output logic                         tready_out,
  output logic [data_width-1:0]        data_out,
  output logic                         tvalid_out,
  output logic                         tlast_out,
  input  logic                         tready_in,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if (data_width != int_width + frac_width) begin : g_bad_q_format
    $error("data_width must equal int_width + frac_width");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [data_width-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  pkt_inc;
  logic                  pkt_dec;

  // All handshake outputs decode from registered state only; tready_in never reaches tready_out.
  always_comb begin
    full       = (level == LVL_FULL);
    tready_out = !full;
    if (PACKET_MODE != 0)
      tvalid_out = (level != '0) && ((pkt_count != '0) || full);
    else
      tvalid_out = (level != '0);
    data_out   = tvalid_out ? mem_data[rd_ptr] : '0;
    tlast_out  = tvalid_out & mem_last[rd_ptr];
    push       = tvalid_in & tready_out;
    pop        = tvalid_out & tready_in;
    pkt_inc    = push & tlast_in;
    pkt_dec    = pop & tlast_out;
  end

  // Storage write: data only, never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_data[wr_ptr] <= data_in;
      mem_last[wr_ptr] <= tlast_in;
    end
  end

  // Control state: pointers, occupancy and stored-packet count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + LVL_ONE;
        2'b01:   pkt_count <= pkt_count - LVL_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Self-checking bench: a cut-through and a store-and-forward FIFO share one stimulus
// stream and are compared every cycle against queue-based models of the buffer.
module tb_axis_stream_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          tvalid_in, tlast_in, tready_in;

  logic          trdy0, tv0, tl0, trdy1, tv1, tl1;
  logic [DW-1:0] dout0, dout1;
  logic [LW-1:0] lvl0, pk0, lvl1, pk1;

  int n_chk  = 0;
  int n_fail = 0;

  beat_t q   [2][$];
  beat_t plog[2][$];

  axis_stream_fifo #(.data_width(DW), .frac_width(6), .int_width(2), .DEPTH(DEPTH), .PACKET_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
    .tready_out(trdy0), .data_out(dout0), .tvalid_out(tv0), .tlast_out(tl0), .tready_in(tready_in),
    .level(lvl0), .pkt_count(pk0));

  axis_stream_fifo #(.data_width(DW), .frac_width(6), .int_width(2), .DEPTH(DEPTH), .PACKET_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
    .tready_out(trdy1), .data_out(dout1), .tvalid_out(tv1), .tlast_out(tl1), .tready_in(tready_in),
    .level(lvl1), .pkt_count(pk1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_pkts(int m);
    int c = 0;
    foreach (q[m][i]) if (q[m][i].l) c++;
    return c;
  endfunction

  function automatic bit m_valid(int m);
    int n = q[m].size();
    if (m == 0) return n > 0;
    return (n > 0) && (m_pkts(m) > 0 || n == DEPTH);
  endfunction

  // Reference model: a FIFO is a queue of beats; outputs follow from its contents.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q[0].delete();
      q[1].delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit pu, po;
        pu = tvalid_in && (q[m].size() < DEPTH);
        po = m_valid(m) && tready_in;
        if (po) begin
          plog[m].push_back(q[m][0]);
          void'(q[m].pop_front());
        end
        if (pu) q[m].push_back('{data_in, tlast_in});
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit v;
      logic [DW-1:0] ed;
      logic el;
      v  = m_valid(m);
      ed = v ? q[m][0].d : '0;
      el = v ? q[m][0].l : 1'b0;
      if (m == 0) begin
        chk("d0_tready", 32'(trdy0), 32'(q[0].size() < DEPTH));
        chk("d0_tvalid", 32'(tv0), 32'(v));
        chk("d0_data", 32'(dout0), 32'(ed));
        chk("d0_tlast", 32'(tl0), 32'(el));
        chk("d0_level", 32'(lvl0), 32'(q[0].size()));
        chk("d0_pkt", 32'(pk0), 32'(m_pkts(0)));
      end else begin
        chk("d1_tready", 32'(trdy1), 32'(q[1].size() < DEPTH));
        chk("d1_tvalid", 32'(tv1), 32'(v));
        chk("d1_data", 32'(dout1), 32'(ed));
        chk("d1_tlast", 32'(tl1), 32'(el));
        chk("d1_level", 32'(lvl1), 32'(q[1].size()));
        chk("d1_pkt", 32'(pk1), 32'(m_pkts(1)));
      end
    end
  end

  // Stimulus is applied 2 time units after each rising edge.
  task automatic send(input logic [DW-1:0] d, input logic l, input int m);
    bit ok = 1'b0;
    data_in = d; tlast_in = l; tvalid_in = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (m == 0) ? trdy0 : trdy1;
      @(posedge clk); #2;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    tvalid_in = 1'b0; tlast_in = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    plog[0].delete();
    plog[1].delete();
  endtask

  initial begin
    int t0;
    reset = 1'b1; tvalid_in = 1'b0; tlast_in = 1'b0; data_in = '0; tready_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("rst_tready", 32'(trdy0), 32'd1);
    chk("rst_tvalid", 32'(tv0), 32'd0);
    chk("rst_level", 32'(lvl0), 32'd0);

    // 1: three beats straight through
    tready_in = 1'b1;
    send(8'h11, 1'b0, 0); send(8'h22, 1'b0, 0); send(8'h33, 1'b1, 0);
    idle(5);
    chk("t1_count", 32'(plog[0].size()), 32'd3);
    if (plog[0].size() == 3) begin
      chk("t1_b0", {23'd0, plog[0][0].l, plog[0][0].d}, 32'h011);
      chk("t1_b1", {23'd0, plog[0][1].l, plog[0][1].d}, 32'h022);
      chk("t1_b2", {23'd0, plog[0][2].l, plog[0][2].d}, 32'h133);
    end
    chk("t1_level", 32'(lvl0), 32'd0);

    // 2: fill while stalled, fifth beat waits upstream
    do_reset();
    tready_in = 1'b0;
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0, 0);
    data_in = 8'h05; tlast_in = 1'b1; tvalid_in = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("t2_level", 32'(lvl0), 32'd4);
    chk("t2_tready", 32'(trdy0), 32'd0);
    tready_in = 1'b1;
    send(8'h05, 1'b1, 0);
    idle(8);
    chk("t2_count", 32'(plog[0].size()), 32'd5);
    for (int i = 0; i < plog[0].size() && i < 5; i++)
      chk("t2_order", 32'(plog[0][i].d), 32'(i + 1));

    // 3: back-to-back streaming across pointer wrap
    do_reset();
    tready_in = 1'b1;
    t0 = int'($time);
    for (int i = 0; i < 3 * DEPTH; i++) send(DW'(i), (i == 3 * DEPTH - 1), 0);
    chk("t3_cycles", 32'((int'($time) - t0) / 10), 32'(3 * DEPTH));
    idle(4);
    chk("t3_count", 32'(plog[0].size()), 32'(3 * DEPTH));
    for (int i = 0; i < plog[0].size(); i++) chk("t3_order", 32'(plog[0][i].d), 32'(i));

    // 4: store-and-forward holds beats until tlast
    do_reset();
    tready_in = 1'b1;
    send(8'hA0, 1'b0, 1); send(8'hA1, 1'b0, 1);
    tvalid_in = 1'b0;
    chk("t4_hold_valid", 32'(tv1), 32'd0);
    chk("t4_hold_level", 32'(lvl1), 32'd2);
    send(8'hA2, 1'b1, 1);
    tvalid_in = 1'b0;
    chk("t4_pkt", 32'(pk1), 32'd1);
    chk("t4_valid", 32'(tv1), 32'd1);
    idle(6);
    chk("t4_count", 32'(plog[1].size()), 32'd3);
    if (plog[1].size() == 3)
      chk("t4_seq", {8'd0, plog[1][0].d, plog[1][1].d, plog[1][2].d}, 32'h00A0A1A2);
    chk("t4_pkt_end", 32'(pk1), 32'd0);

    // 5: packet longer than DEPTH forces release
    do_reset();
    tready_in = 1'b1;
    for (int i = 0; i < 6; i++) send(DW'(8'h60 + i), (i == 5), 1);
    idle(10);
    chk("t5_count", 32'(plog[1].size()), 32'd6);
    for (int i = 0; i < plog[1].size(); i++)
      chk("t5_beat", {23'd0, plog[1][i].l, plog[1][i].d}, {23'd0, (i == 5), DW'(8'h60 + i)});

    // 6: asynchronous reset mid-packet
    do_reset();
    tready_in = 1'b0;
    send(8'h01, 1'b0, 0); send(8'h02, 1'b1, 0); send(8'h03, 1'b0, 0);
    tvalid_in = 1'b0;
    chk("t6_level", 32'(lvl0), 32'd3);
    chk("t6_pkt", 32'(pk0), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async", {26'd0, trdy0, tv0, tl0, lvl0 == 0, pk0 == 0, dout0 == 0}, 32'h27);
    chk("t6_async1", {26'd0, trdy1, tv1, tl1, lvl1 == 0, pk1 == 0, dout1 == 0}, 32'h27);
    @(posedge clk); #2;
    reset = 1'b0;
    plog[0].delete(); plog[1].delete();
    tready_in = 1'b1;
    send(8'h5A, 1'b1, 0);
    idle(4);
    chk("t6_first", (plog[0].size() > 0) ? 32'(plog[0][0].d) : 32'hFFFF, 32'h5A);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      data_in   = DW'($urandom);
      tvalid_in = ($urandom_range(0, 3) != 0);
      tlast_in  = ($urandom_range(0, 4) == 0);
      tready_in = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 400) == 0);
      @(posedge clk); #2;
    end
    reset = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
